fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Write-side controller for the phase-sample async FIFO in the wr_clk domain.
- Shares the single FIFO write port between NUM_CH sample sources using a per-channel one-entry holding register and round-robin grant.
- Tags each written word with its channel ID.
- Honours the FIFO's registered fifo_full, which lags a write, by enforcing a post-write gap.

Parameters:
- NUM_CH, 4, number of requesting sources (2..8).
- DATA_WIDTH, 32, FIFO word width.
- CH_W, $clog2(NUM_CH), width of the channel tag.
- SAMPLE_W, DATA_WIDTH-CH_W, width of the source sample.
- FULL_LAT, 1, idle cycles forced after every write (0..3).

Ports:
- wr_clk  in  1  write-domain clock.
- rst  in  1  synchronous, active-high reset, sampled on wr_clk.
- enable  in  1  accept new samples when 1.
- src_vld  in  NUM_CH  per-channel sample valid.
- src_data  in  NUM_CH*SAMPLE_W  packed samples; channel k occupies [k*SAMPLE_W +: SAMPLE_W].
- src_rdy  out  NUM_CH  per-channel ready; high when that channel's hold register is empty and enable=1.
- fifo_full  in  1  FIFO full flag.
- fifo_data_in_vld  out  1  FIFO write strobe, registered.
- fifo_data_in  out  DATA_WIDTH  {ch_id[CH_W-1:0], sample[SAMPLE_W-1:0]}, registered.
- busy  out  1  high when any sample is pending or state is not ARB.

Behaviour:
- Reset values:
  - hold valid bits pend[] = 0; rr_ptr = 0; state = ARB; gap counter = 0.
  - fifo_data_in_vld = 0; fifo_data_in = 0; busy = 0.
  - src_rdy = 0 while rst=1.
- Reset mid-operation: all pending samples are discarded; the write strobe is 0 from the first edge with rst=1.
- Capture:
  - src_rdy[k] = ~rst & enable & ~pend[k].
  - On an edge with src_vld[k] & src_rdy[k]: the hold register latches the sample and pend[k] is set.
  - The sample is visible to the arbiter in the next cycle.
- States:
  - ARB:
    - If pend != 0 and fifo_full == 0, grant channel g = first set pend bit searching upward (mod NUM_CH) from rr_ptr.
    - On that edge: fifo_data_in_vld <= 1; fifo_data_in <= {g, hold[g]}; pend[g] <= 0; rr_ptr <= (g+1) mod NUM_CH.
    - Next state: GAP if FULL_LAT > 0, otherwise ARB.
    - If no grant: fifo_data_in_vld <= 0 and the state remains ARB.
  - GAP:
    - fifo_data_in_vld <= 0; the counter loads FULL_LAT-1 on entry and counts down; return to ARB at 0.
    - No grant is possible in GAP, regardless of fifo_full.
- Write strobe: fifo_data_in_vld is a single-cycle pulse per word. fifo_data_in holds its last value when vld=0.
- Throughput: at most one write per (1+FULL_LAT) cycles, which protects against the one-cycle lag of the registered full flag.
- fifo_full=1 (including the post-reset period when full reads 1):
  - no grant; pend and rr_ptr are frozen;
  - sources with pend set see src_rdy=0, so the stall back-propagates.
- Simultaneous events:
  - Capture on channel k and grant on channel j≠k in the same edge are both performed.
  - Capture and grant on the same channel cannot coincide, because src_rdy=0 while pend is set.
- enable=0:
  - no new captures;
  - pending samples continue to drain normally;
  - busy falls when pend==0 and state==ARB.
- Round-robin wrap: rr_ptr wraps NUM_CH-1 → 0. A channel re-requesting is served only after every other pending channel.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds ports wr_cnt out 32 and stall_cnt out 32, both reset to 0.
  - wr_cnt increments on every fifo_data_in_vld pulse.
  - stall_cnt increments each cycle in ARB with pend != 0 and fifo_full = 1.
  - Both wrap at 2^32 and are cleared only by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single channel:
  - Stimulus: after reset, release full; ch1 presents 0x00ABCDE with one src_vld pulse.
  - Response: exactly one fifo_data_in_vld pulse, 2 cycles after capture, with fifo_data_in=0x400ABCDE (NUM_CH=4).
  - Then src_rdy[1] returns to 1.
- Round-robin order:
  - Stimulus: ch0..ch3 all captured on the same edge, fifo_full=0, FULL_LAT=1.
  - Response: writes of ch0, ch1, ch2, ch3 on alternate cycles.
  - Then re-request ch0 and ch2: order is ch0 then ch2 (rr_ptr=0 after wrap).
- Backpressure:
  - Stimulus: hold fifo_full=1 for 10 cycles with ch2 pending.
  - Response: no vld, src_rdy[2]=0; with the stats macro, stall_cnt=10.
  - On release, ch2 is written in the first ARB cycle.
- Gap enforcement:
  - Stimulus: FULL_LAT=3, continuous requests on two channels.
  - Response: vld pulses exactly 4 cycles apart, never adjacent.
- Enable drain:
  - Stimulus: 3 channels pending, then enable=0.
  - Response: all src_rdy=0; the 3 pending words are still written; busy falls after the last gap.
- Reset mid-operation:
  - Stimulus: assert rst with 2 channels pending in GAP.
  - Response: vld=0, busy=0, src_rdy=0 during rst.
  - After rst: no stale words are written; with the stats macro, wr_cnt=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter for the phase-sample async FIFO
// Optional write/stall counters are built in when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int SAMPLE_W   = DATA_WIDTH - CH_W,
  parameter int FULL_LAT   = 1
) (
  input  logic                       wr_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          src_vld,
  input  logic [NUM_CH*SAMPLE_W-1:0] src_data,
  output logic [NUM_CH-1:0]          src_rdy,
  input  logic                       fifo_full,
  output logic                       fifo_data_in_vld,
  output logic [DATA_WIDTH-1:0]      fifo_data_in,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [31:0]                wr_cnt,
  output logic [31:0]                stall_cnt,
`endif
  output logic                       busy
);

  typedef enum logic {ARB, GAP} state_t;

  state_t              state_q;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [SAMPLE_W-1:0] hold_q [NUM_CH];
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [1:0]          gap_q;
  logic [NUM_CH-1:0]   cap;
  logic [CH_W-1:0]     gnt_idx, scan_idx;
  logic                gnt_found, grant;
  int                  scan;

  assign src_rdy = {NUM_CH{~rst & enable}} & ~pend_q;
  assign cap     = src_vld & src_rdy;
  assign busy    = ~rst & ((|pend_q) | (state_q != ARB));

  // First pending channel at or above rr_q, wrapping modulo NUM_CH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = int'(rr_q) + i;
      if (scan >= NUM_CH) scan = scan - NUM_CH;
      scan_idx = CH_W'(scan);
      if (!gnt_found && pend_q[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign grant = (state_q == ARB) & gnt_found & ~fifo_full;
  assign rr_d  = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

  // Capture and grant never hit the same channel: src_rdy is low while pending.
  always_comb begin
    pend_d = pend_q | cap;
    if (grant) pend_d = pend_d & ~(NUM_CH'(1) << gnt_idx);
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q          <= ARB;
      pend_q           <= '0;
      rr_q             <= '0;
      gap_q            <= '0;
      fifo_data_in_vld <= 1'b0;
      fifo_data_in     <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      pend_q           <= pend_d;
      fifo_data_in_vld <= grant;
      for (int k = 0; k < NUM_CH; k++) begin
        if (cap[k]) hold_q[k] <= src_data[k*SAMPLE_W +: SAMPLE_W];
      end
      if (grant) begin
        fifo_data_in <= {gnt_idx, hold_q[gnt_idx]};
        rr_q         <= rr_d;
      end
      case (state_q)
        ARB: begin
          if (grant && FULL_LAT > 0) begin
            state_q <= GAP;
            gap_q   <= 2'(FULL_LAT - 1);
          end
        end
        GAP: begin
          if (gap_q == 2'd0) state_q <= ARB;
          else               gap_q   <= gap_q - 2'd1;
        end
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant) wr_cnt <= wr_cnt + 32'd1;
      if (state_q == ARB && (|pend_q) && fifo_full) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
